// File: rtl/riscv_pkg.sv
// Shared definitions for the front end of the pipeline.
//   - Major opcodes recognised by the fetch pre-decoder.
//   - Width of the fetch-to-decode pipeline register.
//   - 2-bit bimodal counter type and its four states.
package riscv_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // {instruction[64:33], pc[32:1], pred[0]}
  localparam int FETCH_DEC_W = 65;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;  // strongly not-taken
  localparam ctr_t WNT = 2'd1;  // weakly not-taken
  localparam ctr_t WT  = 2'd2;  // weakly taken
  localparam ctr_t ST  = 2'd3;  // strongly taken

endpackage

// File: rtl/bht.sv
// Bimodal branch history table: ENTRIES saturating 2-bit counters.
// Ports:
//   clk        clock, updates on rising edge
//   rstn       asynchronous active-low reset; every counter -> WNT
//   rd_idx     lookup index (combinational read)
//   rd_pred    MSB of the addressed counter (1 = predict taken)
//   upd_en     train the counter at upd_idx this cycle
//   upd_idx    index of the counter to train
//   upd_taken  resolved outcome: 1 increments, 0 decrements
// A lookup and an update to the same index in one cycle return the
// pre-update value; the trained value is visible on the next cycle.
module bht
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_pred,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  ctr_t table_q [ENTRIES];

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

  assign rd_pred = table_q[rd_idx][1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= WNT;
    end else if (upd_en) begin
      table_q[upd_idx] <= sat_update(table_q[upd_idx], upd_taken);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Owns the PC, drives the instruction-memory address, pre-decodes the
// returned word to predict control flow (bimodal table for conditional
// branches, always-taken for JAL) and registers {inst, pc, pred} for
// decode.
// Ports:
//   clk, rstn      clock / asynchronous active-low reset
//   stall          hold PC and fetch_dec_reg
//   redirect       execute mispredict: load redirect_pc, emit a bubble
//   redirect_pc    corrected next PC
//   upd_valid      train the counter for upd_pc with upd_taken
//   upd_pc         PC of the resolved conditional branch
//   upd_taken      resolved outcome
//   imem_addr      instruction-memory address (= PC register)
//   imem_rdata     instruction at imem_addr, same cycle
//   fetch_dec_reg  {instruction[64:33], pc[32:1], pred[0]}
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_ENTRIES = 64,
  parameter int          BHT_BITS    = $clog2(BHT_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  input  logic                   upd_valid,
  input  logic [31:0]            upd_pc,
  input  logic                   upd_taken,
  output logic [31:0]            imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [FETCH_DEC_W-1:0] fetch_dec_reg
);

  logic [31:0]        pc_p0;
  logic [6:0]         opcode_p0;
  logic signed [31:0] imm_b_p0;
  logic signed [31:0] imm_j_p0;
  logic [31:0]        tgt_b_p0;
  logic [31:0]        tgt_j_p0;
  logic               bht_pred_p0;
  logic               pred_p0;
  logic [31:0]        next_pc_p0;

  // Only the counter-index field of the training PC selects a counter;
  // the remaining bits are deliberately ignored.
  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc[31:BHT_BITS+2], upd_pc[1:0]};

  bht #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk       (clk),
    .rstn      (rstn),
    .rd_idx    (pc_p0[BHT_BITS+1:2]),
    .rd_pred   (bht_pred_p0),
    .upd_en    (upd_valid),
    .upd_idx   (upd_pc[BHT_BITS+1:2]),
    .upd_taken (upd_taken)
  );

  assign imem_addr = pc_p0;
  assign opcode_p0 = imem_rdata[6:0];

  // Stage p0: pre-decode of the word returned for the current PC.
  assign imm_b_p0 = $signed({{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                             imem_rdata[30:25], imem_rdata[11:8], 1'b0});
  assign imm_j_p0 = $signed({{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                             imem_rdata[20], imem_rdata[30:21], 1'b0});

  // Two's-complement add: wraps modulo 2^32, no overflow detection.
  assign tgt_b_p0 = pc_p0 + $unsigned(imm_b_p0);
  assign tgt_j_p0 = pc_p0 + $unsigned(imm_j_p0);

  always_comb begin
    pred_p0    = 1'b0;
    next_pc_p0 = pc_p0 + 32'd4;
    unique case (opcode_p0)
      OPC_BRANCH: begin
        pred_p0 = bht_pred_p0;
        if (bht_pred_p0) next_pc_p0 = tgt_b_p0;
      end
      OPC_JAL: begin
        pred_p0    = 1'b1;
        next_pc_p0 = tgt_j_p0;
      end
      default: ;
    endcase
  end

  // Stage p0 -> p1: PC update and fetch/decode register.
  // A redirect wins over stall and inserts an all-zero bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_p0         <= RESET_PC;
      fetch_dec_reg <= '0;
    end else if (redirect) begin
      pc_p0         <= redirect_pc;
      fetch_dec_reg <= '0;
    end else if (!stall) begin
      pc_p0         <= next_pc_p0;
      fetch_dec_reg <= {imem_rdata, pc_p0, pred_p0};
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] ADDI   = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2  = 32'h0020_0113;  // addi x2,x0,2
  localparam logic [31:0] JAL16  = 32'h0100_006F;  // jal x0,+16
  localparam logic [31:0] JALM4  = 32'hFFDF_F06F;  // jal x0,-4
  localparam logic [31:0] BEQ8   = 32'h0000_0463;  // beq x0,x0,+8

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [64:0] fetch_dec_reg;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC    (32'h0000_0000),
    .BHT_ENTRIES (64)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .fetch_dec_reg (fetch_dec_reg)
  );

  assign imem_rdata = mem[imem_addr[8:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] fdr(input logic [31:0] inst, input logic [31:0] pc,
                                      input logic pred);
    return {inst, pc, pred};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = ADDI;
    mem[32'h08 >> 2]  = JAL16;
    mem[32'h20 >> 2]  = BEQ8;
    mem[32'h40 >> 2]  = ADDI2;
    mem[32'h104 >> 2] = JALM4;

    rstn = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    #2;
    check("rst_addr", {33'd0, imem_addr}, {33'd0, 32'h0});
    check("rst_fdr", fetch_dec_reg, '0);
    @(negedge clk);
    rstn = 1'b1;

    // Straight-line fetch
    tick();
    check("seq0_fdr", fetch_dec_reg, fdr(ADDI, 32'h0, 1'b0));
    check("seq0_addr", {33'd0, imem_addr}, {33'd0, 32'h4});
    tick();
    check("seq1_fdr", fetch_dec_reg, fdr(ADDI, 32'h4, 1'b0));
    check("seq1_addr", {33'd0, imem_addr}, {33'd0, 32'h8});
    // JAL +16 at 0x8
    tick();
    check("jal_fdr", fetch_dec_reg, fdr(JAL16, 32'h8, 1'b1));
    check("jal_addr", {33'd0, imem_addr}, {33'd0, 32'h18});
    tick();
    tick();
    check("pre_beq_addr", {33'd0, imem_addr}, {33'd0, 32'h20});
    // BEQ with counter at WNT: not taken
    tick();
    check("beq_wnt_fdr", fetch_dec_reg, fdr(BEQ8, 32'h20, 1'b0));
    check("beq_wnt_addr", {33'd0, imem_addr}, {33'd0, 32'h24});

    // Train 0x20 taken twice: 1 -> 2 -> 3
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1;
    tick();
    tick();
    upd_valid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    check("redir_bubble", fetch_dec_reg, '0);
    check("redir_addr", {33'd0, imem_addr}, {33'd0, 32'h20});
    redirect = 1'b0;
    tick();
    check("beq_st_fdr", fetch_dec_reg, fdr(BEQ8, 32'h20, 1'b1));
    check("beq_st_addr", {33'd0, imem_addr}, {33'd0, 32'h28});

    // Two more taken (saturate at 3), one not-taken -> 2, still predicts taken
    upd_valid = 1'b1; upd_taken = 1'b1;
    tick();
    tick();
    upd_taken = 1'b0;
    tick();
    upd_valid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    check("beq_sat_fdr", fetch_dec_reg, fdr(BEQ8, 32'h20, 1'b1));
    check("beq_sat_addr", {33'd0, imem_addr}, {33'd0, 32'h28});

    // Stall at pc 0x40
    redirect = 1'b1; redirect_pc = 32'h3C;
    tick();
    redirect = 1'b0;
    tick();
    check("pre_stall_fdr", fetch_dec_reg, fdr(ADDI, 32'h3C, 1'b0));
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", {33'd0, imem_addr}, {33'd0, 32'h40});
      check("stall_fdr", fetch_dec_reg, fdr(ADDI, 32'h3C, 1'b0));
    end
    stall = 1'b0;
    tick();
    check("unstall_fdr", fetch_dec_reg, fdr(ADDI2, 32'h40, 1'b0));
    check("unstall_addr", {33'd0, imem_addr}, {33'd0, 32'h44});

    // Redirect overrides stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    check("redir_stall_fdr", fetch_dec_reg, '0);
    check("redir_stall_addr", {33'd0, imem_addr}, {33'd0, 32'h100});
    stall = 1'b0; redirect = 1'b0;
    tick();
    check("post_redir_fdr", fetch_dec_reg, fdr(ADDI, 32'h100, 1'b0));
    // Backward JAL -4 at 0x104
    tick();
    check("jal_back_fdr", fetch_dec_reg, fdr(JALM4, 32'h104, 1'b1));
    check("jal_back_addr", {33'd0, imem_addr}, {33'd0, 32'h100});

    // Asynchronous reset between edges
    #3;
    rstn = 1'b0;
    #1;
    check("arst_fdr", fetch_dec_reg, '0);
    check("arst_addr", {33'd0, imem_addr}, {33'd0, 32'h0});
    #1;
    rstn = 1'b1;
    tick();
    check("arst_first_fdr", fetch_dec_reg, fdr(ADDI, 32'h0, 1'b0));
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    // Counter back to WNT; train taken in the same cycle as the lookup
    redirect = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1;
    tick();
    check("arst_beq_fdr", fetch_dec_reg, fdr(BEQ8, 32'h20, 1'b0));
    check("arst_beq_addr", {33'd0, imem_addr}, {33'd0, 32'h24});
    upd_valid = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect = 1'b0;
    tick();
    check("same_cyc_upd_fdr", fetch_dec_reg, fdr(BEQ8, 32'h20, 1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
